// File: rtl/mem_stage_hs.sv
// MEM stage between EX and WB: waits for the data-memory response, aligns load data,
// selects the final result and forwards it to ID. Flush cancels a still-outstanding response.
module mem_stage_hs #(
    parameter  int DATA_W = 32,
    localparam int OFF_W  = $clog2(DATA_W/8)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              es_to_ms_valid,
    output logic              ms_allowin,
    input  logic [4:0]        es_ld_op,
    input  logic              es_res_from_mem,
    input  logic              es_req_issued,
    input  logic [1:0]        es_res_sel,
    input  logic              es_gr_we,
    input  logic [4:0]        es_dest,
    input  logic [31:0]       es_alu_result,
    input  logic [31:0]       es_csr_rdata,
    input  logic [31:0]       es_pc,
    input  logic              es_is_exc,
    input  logic [31:0]       cnt_value_l,
    input  logic [31:0]       cnt_value_h,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    input  logic              ms_flush,
    input  logic              ws_allowin,
    output logic              ms_to_ws_valid,
    output logic              ms_gr_we,
    output logic [4:0]        ms_dest,
    output logic [31:0]       ms_result,
    output logic [31:0]       ms_pc,
    output logic              ms_is_exc,
    output logic [4:0]        ms_to_ds_dest,
    output logic [31:0]       ms_to_ds_result,
    output logic              ms_to_ds_res_ok,
    output logic              ms_to_ds_is_exc,
    output logic [1:0]        ms_dbg_state,
    output logic              ms_dbg_proto_err
);

    // Handshake: a transfer happens in a cycle where the producer's valid and the
    // consumer's allowin are both high; valid never depends on allowin of the same stage.
    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_WAIT   = 2'd1,
        S_READY  = 2'd2,
        S_CANCEL = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [4:0]        ld_op_q;
    logic              res_from_mem_q;
    logic [1:0]        res_sel_q;
    logic              gr_we_q;
    logic [4:0]        dest_q;
    logic [31:0]       alu_result_q;
    logic [31:0]       csr_rdata_q;
    logic [31:0]       pc_q;
    logic              is_exc_q;
    logic [DATA_W-1:0] rdata_buf_q;

    logic   ready_go;
    logic   accept;
    logic   in_flight;
    logic   buf_capture;
    state_e accept_state;

    assign ready_go     = (state_q == S_READY) | ((state_q == S_WAIT) & data_sram_data_ok);
    assign ms_allowin   = (state_q != S_CANCEL) & ((state_q == S_EMPTY) | (ready_go & ws_allowin));
    assign accept       = es_to_ms_valid & ms_allowin & ~ms_flush;
    assign accept_state = es_req_issued ? S_WAIT : S_READY;
    assign in_flight    = (state_q == S_WAIT) | (state_q == S_READY);

    always_comb begin
        state_d     = state_q;
        buf_capture = 1'b0;
        unique case (state_q)
            S_EMPTY: begin
                if (accept) state_d = accept_state;
            end
            S_WAIT: begin
                if (ms_flush) begin
                    state_d = data_sram_data_ok ? S_EMPTY : S_CANCEL;
                end else if (data_sram_data_ok) begin
                    if (ws_allowin) begin
                        state_d = accept ? accept_state : S_EMPTY;
                    end else begin
                        state_d     = S_READY;
                        buf_capture = 1'b1;
                    end
                end
            end
            S_READY: begin
                if (ms_flush) state_d = S_EMPTY;
                else if (ws_allowin) state_d = accept ? accept_state : S_EMPTY;
            end
            S_CANCEL: begin
                if (data_sram_data_ok) state_d = S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ld_op_q        <= '0;
            res_from_mem_q <= 1'b0;
            res_sel_q      <= '0;
            gr_we_q        <= 1'b0;
            dest_q         <= '0;
            alu_result_q   <= '0;
            csr_rdata_q    <= '0;
            pc_q           <= '0;
            is_exc_q       <= 1'b0;
        end else if (accept) begin
            ld_op_q        <= es_ld_op;
            res_from_mem_q <= es_res_from_mem;
            res_sel_q      <= es_res_sel;
            gr_we_q        <= es_gr_we;
            dest_q         <= es_dest;
            alu_result_q   <= es_alu_result;
            csr_rdata_q    <= es_csr_rdata;
            pc_q           <= es_pc;
            is_exc_q       <= es_is_exc;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_buf_q <= '0;
        end else if (buf_capture) begin
            rdata_buf_q <= data_sram_rdata;
        end
    end

    // Live response data while waiting gives zero added latency; the buffer covers WB stalls.
    logic [DATA_W-1:0] mem_data;
    logic [OFF_W-1:0]  off;
    logic [31:0]       word;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       load_val;

    assign mem_data = (state_q == S_WAIT) ? data_sram_rdata : rdata_buf_q;
    assign off      = alu_result_q[OFF_W-1:0];

    generate
        if (DATA_W == 64) begin : g_word64
            assign word = off[OFF_W-1] ? mem_data[63:32] : mem_data[31:0];
        end else begin : g_word32
            assign word = mem_data[31:0];
        end
    endgenerate

    always_comb begin
        byte_v = word[7:0];
        unique case (off[1:0])
            2'd0: byte_v = word[7:0];
            2'd1: byte_v = word[15:8];
            2'd2: byte_v = word[23:16];
            2'd3: byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = off[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_val = word;
        if (ld_op_q[1])      load_val = {{24{byte_v[7]}}, byte_v};
        else if (ld_op_q[2]) load_val = {{16{half_v[15]}}, half_v};
        else if (ld_op_q[3]) load_val = {24'd0, byte_v};
        else if (ld_op_q[4]) load_val = {16'd0, half_v};
        else if (ld_op_q[0]) load_val = word;
    end

    always_comb begin
        ms_result = alu_result_q;
        if (res_from_mem_q) begin
            ms_result = load_val;
        end else begin
            unique case (res_sel_q)
                2'd0: ms_result = alu_result_q;
                2'd1: ms_result = csr_rdata_q;
                2'd2: ms_result = cnt_value_l;
                2'd3: ms_result = cnt_value_h;
                default: ms_result = alu_result_q;
            endcase
        end
    end

    assign ms_to_ws_valid   = ready_go & ~ms_flush;
    assign ms_gr_we         = gr_we_q;
    assign ms_dest          = dest_q;
    assign ms_pc            = pc_q;
    assign ms_is_exc        = is_exc_q;
    assign ms_to_ds_dest    = (in_flight & gr_we_q) ? dest_q : 5'd0;
    assign ms_to_ds_result  = ms_result;
    assign ms_to_ds_res_ok  = ready_go;
    assign ms_to_ds_is_exc  = in_flight & is_exc_q;
    assign ms_dbg_state     = state_q;
    // Only one request is ever outstanding, so a response outside WAIT/CANCEL is illegal.
    assign ms_dbg_proto_err = data_sram_data_ok & ((state_q == S_EMPTY) | (state_q == S_READY));

endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: 32-bit and 64-bit bus instances share stimulus; a scoreboard
// queue of {dest,result} is popped on every WB handoff of the 32-bit instance.
module tb_mem_stage_hs;

    logic        clk;
    logic        resetn;
    logic        es_to_ms_valid;
    logic [4:0]  es_ld_op;
    logic        es_res_from_mem;
    logic        es_req_issued;
    logic [1:0]  es_res_sel;
    logic        es_gr_we;
    logic [4:0]  es_dest;
    logic [31:0] es_alu_result;
    logic [31:0] es_csr_rdata;
    logic [31:0] es_pc;
    logic        es_is_exc;
    logic [31:0] cnt_value_l;
    logic [31:0] cnt_value_h;
    logic        data_ok;
    logic [63:0] rdata64;
    logic        ms_flush;
    logic        ws_allowin;

    logic        ms_allowin, ms_to_ws_valid, ms_gr_we, ms_is_exc;
    logic [4:0]  ms_dest, ms_to_ds_dest;
    logic [31:0] ms_result, ms_pc, ms_to_ds_result;
    logic        ms_to_ds_res_ok, ms_to_ds_is_exc, proto_err;
    logic [1:0]  state;

    logic        w_allowin, w_valid, w_gr_we, w_is_exc, w_res_ok, w_ds_exc, w_perr;
    logic [4:0]  w_dest, w_ds_dest;
    logic [31:0] w_result, w_pc, w_ds_result;
    logic [1:0]  w_state;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [36:0] exp_q[$];
    logic [36:0] exp_v;
    bit mon_en = 1'b1;

    localparam logic [1:0] ST_EMPTY = 2'd0, ST_WAIT = 2'd1, ST_READY = 2'd2, ST_CANCEL = 2'd3;

    mem_stage_hs #(.DATA_W(32)) dut32 (
        .clk(clk), .resetn(resetn), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_ld_op(es_ld_op), .es_res_from_mem(es_res_from_mem), .es_req_issued(es_req_issued),
        .es_res_sel(es_res_sel), .es_gr_we(es_gr_we), .es_dest(es_dest),
        .es_alu_result(es_alu_result), .es_csr_rdata(es_csr_rdata), .es_pc(es_pc),
        .es_is_exc(es_is_exc), .cnt_value_l(cnt_value_l), .cnt_value_h(cnt_value_h),
        .data_sram_data_ok(data_ok), .data_sram_rdata(rdata64[31:0]), .ms_flush(ms_flush),
        .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid), .ms_gr_we(ms_gr_we),
        .ms_dest(ms_dest), .ms_result(ms_result), .ms_pc(ms_pc), .ms_is_exc(ms_is_exc),
        .ms_to_ds_dest(ms_to_ds_dest), .ms_to_ds_result(ms_to_ds_result),
        .ms_to_ds_res_ok(ms_to_ds_res_ok), .ms_to_ds_is_exc(ms_to_ds_is_exc),
        .ms_dbg_state(state), .ms_dbg_proto_err(proto_err)
    );

    mem_stage_hs #(.DATA_W(64)) dut64 (
        .clk(clk), .resetn(resetn), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(w_allowin),
        .es_ld_op(es_ld_op), .es_res_from_mem(es_res_from_mem), .es_req_issued(es_req_issued),
        .es_res_sel(es_res_sel), .es_gr_we(es_gr_we), .es_dest(es_dest),
        .es_alu_result(es_alu_result), .es_csr_rdata(es_csr_rdata), .es_pc(es_pc),
        .es_is_exc(es_is_exc), .cnt_value_l(cnt_value_l), .cnt_value_h(cnt_value_h),
        .data_sram_data_ok(data_ok), .data_sram_rdata(rdata64), .ms_flush(ms_flush),
        .ws_allowin(ws_allowin), .ms_to_ws_valid(w_valid), .ms_gr_we(w_gr_we),
        .ms_dest(w_dest), .ms_result(w_result), .ms_pc(w_pc), .ms_is_exc(w_is_exc),
        .ms_to_ds_dest(w_ds_dest), .ms_to_ds_result(w_ds_result),
        .ms_to_ds_res_ok(w_res_ok), .ms_to_ds_is_exc(w_ds_exc),
        .ms_dbg_state(w_state), .ms_dbg_proto_err(w_perr)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every WB handoff must match the oldest expected {dest,result}
    always @(negedge clk) begin
        if (resetn && mon_en && ms_to_ws_valid && ws_allowin) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got dest=%0d result=%h, required no output", ms_dest, ms_result);
            end else begin
                exp_v = exp_q.pop_front();
                if ({ms_dest, ms_result} !== exp_v)
                    $display("FAIL sb_result: got dest=%0d result=%h, required dest=%0d result=%h",
                             ms_dest, ms_result, exp_v[36:32], exp_v[31:0]);
                else
                    pass_cnt++;
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] ld_op, input logic rfm, input logic req,
                         input logic [1:0] sel, input logic [4:0] dest, input logic [31:0] alu);
        es_to_ms_valid  = 1'b1;
        es_ld_op        = ld_op;
        es_res_from_mem = rfm;
        es_req_issued   = req;
        es_res_sel      = sel;
        es_gr_we        = 1'b1;
        es_dest         = dest;
        es_alu_result   = alu;
        es_pc           = 32'h1c00_0000 + {22'd0, dest, 2'b00};
    endtask

    function automatic logic [31:0] model_load(input logic [4:0] op, input logic [31:0] addr,
                                                input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'((d >> (8 * addr[1:0])) & 32'hFF);
        h = 16'((d >> (16 * addr[1])) & 32'hFFFF);
        case (op)
            5'b00010: return {{24{b[7]}}, b};
            5'b00100: return {{16{h[15]}}, h};
            5'b01000: return {24'd0, b};
            5'b10000: return {16'd0, h};
            default:  return d;
        endcase
    endfunction

    task automatic test_reset();
        @(negedge clk);
        total_cnt++; if (ms_allowin !== 1'b1) $display("FAIL rst_allowin: got %b required 1", ms_allowin); else pass_cnt++;
        total_cnt++; if (ms_to_ws_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", ms_to_ws_valid); else pass_cnt++;
        total_cnt++; if ({ms_result, ms_pc, ms_dest} !== 69'd0) $display("FAIL rst_payload: got %h %h %h required 0", ms_result, ms_pc, ms_dest); else pass_cnt++;
        total_cnt++; if (state !== ST_EMPTY) $display("FAIL rst_state: got %0d required %0d", state, ST_EMPTY); else pass_cnt++;
        resetn = 1'b1;
    endtask

    task automatic test_alu();
        ws_allowin = 1'b1;
        step();
        issue(5'b00001, 1'b0, 1'b0, 2'd0, 5'd5, 32'h0000_1234);
        exp_q.push_back({5'd5, 32'h0000_1234});
        step();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        total_cnt++; if (ms_to_ds_dest !== 5'd5) $display("FAIL alu_fwd_dest: got %0d required 5", ms_to_ds_dest); else pass_cnt++;
        total_cnt++; if (ms_to_ds_res_ok !== 1'b1) $display("FAIL alu_res_ok: got %b required 1", ms_to_ds_res_ok); else pass_cnt++;
        total_cnt++; if (ms_pc !== 32'h1c00_0014) $display("FAIL alu_pc: got %h required 1c000014", ms_pc); else pass_cnt++;
        step();
        total_cnt++; if (ms_to_ds_dest !== 5'd0 || ms_allowin !== 1'b1) $display("FAIL alu_empty: got dest=%0d allowin=%b required 0/1", ms_to_ds_dest, ms_allowin); else pass_cnt++;
    endtask

    task automatic test_back_to_back_sel();
        es_csr_rdata = 32'hC5C5_0001;
        issue(5'b00001, 1'b0, 1'b0, 2'd1, 5'd1, 32'h0);
        exp_q.push_back({5'd1, 32'hC5C5_0001});
        step();
        issue(5'b00001, 1'b0, 1'b0, 2'd2, 5'd2, 32'h0);
        exp_q.push_back({5'd2, 32'hA5A5_1111});
        @(negedge clk);
        total_cnt++; if (ms_allowin !== 1'b1) $display("FAIL b2b_allowin: got %b required 1", ms_allowin); else pass_cnt++;
        step();
        issue(5'b00001, 1'b0, 1'b0, 2'd3, 5'd3, 32'h0);
        exp_q.push_back({5'd3, 32'h5A5A_2222});
        step();
        es_to_ms_valid = 1'b0;
        step();
    endtask

    task automatic test_load_b();
        issue(5'b00010, 1'b1, 1'b1, 2'd0, 5'd7, 32'h1c00_1001);
        exp_q.push_back({5'd7, 32'hFFFF_FFAA});
        step();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        total_cnt++; if (state !== ST_WAIT) $display("FAIL ldb_state: got %0d required %0d", state, ST_WAIT); else pass_cnt++;
        total_cnt++; if (ms_to_ws_valid !== 1'b0 || ms_to_ds_res_ok !== 1'b0) $display("FAIL ldb_wait_out: got valid=%b res_ok=%b required 0/0", ms_to_ws_valid, ms_to_ds_res_ok); else pass_cnt++;
        total_cnt++; if (ms_to_ds_dest !== 5'd7) $display("FAIL ldb_fwd_dest: got %0d required 7", ms_to_ds_dest); else pass_cnt++;
        step();
        data_ok = 1'b1;
        rdata64 = {32'h0, 32'h8899_AABB};
        @(negedge clk);
        total_cnt++; if (ms_to_ds_res_ok !== 1'b1) $display("FAIL ldb_res_ok: got %b required 1", ms_to_ds_res_ok); else pass_cnt++;
        step();
        data_ok = 1'b0;
        total_cnt++; if (state !== ST_EMPTY) $display("FAIL ldb_done: got %0d required %0d", state, ST_EMPTY); else pass_cnt++;
    endtask

    task automatic test_load_hu_stall();
        ws_allowin = 1'b0;
        issue(5'b10000, 1'b1, 1'b1, 2'd0, 5'd8, 32'h1c00_2002);
        exp_q.push_back({5'd8, 32'h0000_8899});
        step();
        es_to_ms_valid = 1'b0;
        data_ok = 1'b1;
        rdata64 = {32'h0, 32'h8899_AABB};
        @(negedge clk);
        total_cnt++; if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0) $display("FAIL hu_dok: got valid=%b allowin=%b required 1/0", ms_to_ws_valid, ms_allowin); else pass_cnt++;
        step();
        data_ok = 1'b0;
        rdata64 = {32'h0, 32'hDEAD_BEEF};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++; if (ms_result !== 32'h0000_8899) $display("FAIL hu_hold_result: cycle %0d got %h required 00008899", i, ms_result); else pass_cnt++;
            total_cnt++; if (ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b1) $display("FAIL hu_hold_hs: cycle %0d got allowin=%b valid=%b required 0/1", i, ms_allowin, ms_to_ws_valid); else pass_cnt++;
            step();
        end
        ws_allowin = 1'b1;
        step();
    endtask

    task automatic test_flush_wait();
        issue(5'b00001, 1'b1, 1'b1, 2'd0, 5'd9, 32'h1c00_3000);
        step();
        es_to_ms_valid = 1'b0;
        ms_flush = 1'b1;
        @(negedge clk);
        total_cnt++; if (ms_to_ws_valid !== 1'b0) $display("FAIL flw_valid: got %b required 0", ms_to_ws_valid); else pass_cnt++;
        step();
        ms_flush = 1'b0;
        issue(5'b00001, 1'b0, 1'b0, 2'd0, 5'd10, 32'h0000_0BAD);
        @(negedge clk);
        total_cnt++; if (state !== ST_CANCEL || ms_allowin !== 1'b0) $display("FAIL flw_cancel: got state=%0d allowin=%b required %0d/0", state, ms_allowin, ST_CANCEL); else pass_cnt++;
        step();
        es_to_ms_valid = 1'b0;
        data_ok = 1'b1;
        rdata64 = {32'h0, 32'h1357_9BDF};
        @(negedge clk);
        total_cnt++; if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b0) $display("FAIL flw_stale: got valid=%b allowin=%b required 0/0", ms_to_ws_valid, ms_allowin); else pass_cnt++;
        step();
        data_ok = 1'b0;
        total_cnt++; if (state !== ST_EMPTY || ms_allowin !== 1'b1) $display("FAIL flw_empty: got state=%0d allowin=%b required %0d/1", state, ms_allowin, ST_EMPTY); else pass_cnt++;
    endtask

    task automatic test_flush_ready();
        ws_allowin = 1'b0;
        issue(5'b00001, 1'b0, 1'b0, 2'd0, 5'd11, 32'h0000_7777);
        step();
        es_to_ms_valid = 1'b0;
        ms_flush = 1'b1;
        @(negedge clk);
        total_cnt++; if (ms_to_ws_valid !== 1'b0) $display("FAIL flr_valid: got %b required 0", ms_to_ws_valid); else pass_cnt++;
        step();
        ms_flush = 1'b0;
        ws_allowin = 1'b1;
        total_cnt++; if (state !== ST_EMPTY) $display("FAIL flr_empty: got %0d required %0d", state, ST_EMPTY); else pass_cnt++;
    endtask

    task automatic test_bus64();
        issue(5'b00001, 1'b1, 1'b1, 2'd0, 5'd12, 32'h1c00_4004);
        exp_q.push_back({5'd12, 32'h5566_7788});
        step();
        es_to_ms_valid = 1'b0;
        data_ok = 1'b1;
        rdata64 = 64'h1122_3344_5566_7788;
        @(negedge clk);
        total_cnt++; if (w_result !== 32'h1122_3344) $display("FAIL b64_ldw: got %h required 11223344", w_result); else pass_cnt++;
        step();
        data_ok = 1'b0;
        issue(5'b00100, 1'b1, 1'b1, 2'd0, 5'd13, 32'h1c00_4006);
        exp_q.push_back({5'd13, 32'h0000_5566});
        step();
        es_to_ms_valid = 1'b0;
        data_ok = 1'b1;
        @(negedge clk);
        total_cnt++; if (w_result !== 32'h0000_1122) $display("FAIL b64_ldh: got %h required 00001122", w_result); else pass_cnt++;
        step();
        data_ok = 1'b0;
    endtask

    task automatic test_random();
        logic [4:0]  op;
        logic [31:0] addr, d;
        int lat;
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                issue(5'b00001, 1'b0, 1'b0, 2'd0, 5'(n + 1), d);
                exp_q.push_back({5'(n + 1), d});
                step();
                es_to_ms_valid = 1'b0;
                step();
            end else begin
                op   = 5'b00001 << $urandom_range(0, 4);
                addr = $urandom;
                issue(op, 1'b1, 1'b1, 2'd0, 5'(n + 1), addr);
                step();
                es_to_ms_valid = 1'b0;
                lat = $urandom_range(0, 2);
                for (int k = 0; k < lat; k++) step();
                d = $urandom;
                data_ok = 1'b1;
                rdata64 = {32'h0, d};
                exp_q.push_back({5'(n + 1), model_load(op, addr, d)});
                step();
                data_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        issue(5'b00001, 1'b1, 1'b1, 2'd0, 5'd14, 32'h1c00_5000);
        step();
        es_to_ms_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        total_cnt++; if (state !== ST_EMPTY || ms_allowin !== 1'b1) $display("FAIL rmw_state: got state=%0d allowin=%b required %0d/1", state, ms_allowin, ST_EMPTY); else pass_cnt++;
        total_cnt++; if (ms_to_ds_dest !== 5'd0 || ms_pc !== 32'd0 || ms_to_ws_valid !== 1'b0) $display("FAIL rmw_outputs: got dest=%0d pc=%h valid=%b required 0", ms_to_ds_dest, ms_pc, ms_to_ws_valid); else pass_cnt++;
        #1 resetn = 1'b1;
        @(negedge clk);
        data_ok = 1'b1;
        #1;
        total_cnt++; if (proto_err !== 1'b1 || ms_to_ws_valid !== 1'b0) $display("FAIL rmw_stray: got perr=%b valid=%b required 1/0", proto_err, ms_to_ws_valid); else pass_cnt++;
        #1 data_ok = 1'b0;
        #1;
        total_cnt++; if (proto_err !== 1'b0) $display("FAIL rmw_perr_clear: got %b required 0", proto_err); else pass_cnt++;
    endtask

    initial begin
        resetn = 1'b0;
        es_to_ms_valid = 1'b0; es_ld_op = '0; es_res_from_mem = 1'b0; es_req_issued = 1'b0;
        es_res_sel = '0; es_gr_we = 1'b0; es_dest = '0; es_alu_result = '0; es_csr_rdata = '0;
        es_pc = '0; es_is_exc = 1'b0; cnt_value_l = 32'hA5A5_1111; cnt_value_h = 32'h5A5A_2222;
        data_ok = 1'b0; rdata64 = '0; ms_flush = 1'b0; ws_allowin = 1'b1;
        repeat (3) @(posedge clk);
        test_reset();
        test_alu();
        test_back_to_back_sel();
        test_load_b();
        test_load_hu_stall();
        test_flush_wait();
        test_flush_ready();
        test_bus64();
        test_random();
        test_reset_mid_wait();
        repeat (2) step();
        total_cnt++; if (exp_q.size() != 0) $display("FAIL sb_drain: got %0d pending required 0", exp_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
